// File: rtl/bias2_pkg.sv
// ============================================================================
// Module      : bias2_pkg
// Description : Shared constants and FSM state type for the bias2 delta path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bias2_pkg;
  localparam int         N_OUT      = 5;
  localparam int         DATA_W     = 16;
  localparam logic [3:0] CMD_COMMIT = 4'b1111;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCALE  = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/bias2_delta_gen_if.sv
// ============================================================================
// Module      : bias2_delta_gen_if
// Description : Error-sample valid/ready channel feeding the bias2 delta gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bias2_delta_gen_if;
  import bias2_pkg::*;

  logic                     err_valid;
  logic                     err_ready;
  logic signed [DATA_W-1:0] err_1;
  logic signed [DATA_W-1:0] err_2;
  logic signed [DATA_W-1:0] err_3;
  logic signed [DATA_W-1:0] err_4;
  logic signed [DATA_W-1:0] err_5;

  modport master (
    output err_valid, err_1, err_2, err_3, err_4, err_5,
    input  err_ready
  );

  modport slave (
    input  err_valid, err_1, err_2, err_3, err_4, err_5,
    output err_ready
  );
endinterface

`default_nettype wire

// File: rtl/bias2_scale_sat.sv
// ============================================================================
// Module      : bias2_scale_sat
// Description : One lane: arithmetic shift, negate, narrow to 16 bits.
//               Clamping enabled by macro BIAS2_DELTA_SAT_EN, else wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bias2_scale_sat
  import bias2_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  wire logic signed [ACC_W-1:0]  acc,
  input  wire logic        [3:0]        shift,
  output logic signed      [DATA_W-1:0] delta,
  output logic                          sat
);

  logic signed [ACC_W-1:0] w_shr;
  logic signed [ACC_W:0]   w_neg;

  // One extra bit so negating the most negative accumulator cannot overflow.
  assign w_shr = acc >>> shift;
  assign w_neg = -((ACC_W+1)'(w_shr));

`ifdef BIAS2_DELTA_SAT_EN
  logic w_fits;

  assign w_fits = (&w_neg[ACC_W:DATA_W-1]) | ~(|w_neg[ACC_W:DATA_W-1]);
  assign sat    = ~w_fits;
  assign delta  = w_fits      ? w_neg[DATA_W-1:0] :
                  w_neg[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                 {1'b0, {(DATA_W-1){1'b1}}};
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_neg[ACC_W:DATA_W];
  assign sat         = 1'b0;
  assign delta       = w_neg[DATA_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/bias2_delta_gen.sv
// ============================================================================
// Module      : bias2_delta_gen
// Description : Mini-batch error accumulator producing bias2 commit deltas.
//               Optional clamping via macro BIAS2_DELTA_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bias2_delta_gen
  import bias2_pkg::*;
#(
  parameter int BATCH = 4,
  parameter int ACC_W = 24
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  bias2_delta_gen_if.slave              err_if,
  input  wire logic [3:0]               lr_shift,
  input  wire logic                     flush,
  output logic      [3:0]               ctrl,
  output logic      [3:0]               sel,
  output logic signed [DATA_W-1:0]      deltab2_1,
  output logic signed [DATA_W-1:0]      deltab2_2,
  output logic signed [DATA_W-1:0]      deltab2_3,
  output logic signed [DATA_W-1:0]      deltab2_4,
  output logic signed [DATA_W-1:0]      deltab2_5,
  output logic                          busy,
  output logic                          sat_flag
);

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_count;
  logic signed [ACC_W-1:0]  r_acc   [N_OUT];
  logic signed [DATA_W-1:0] w_err   [N_OUT];
  logic signed [DATA_W-1:0] w_delta [N_OUT];
  logic signed [DATA_W-1:0] r_delta [N_OUT];
  logic [N_OUT-1:0]         w_sat;
  logic [3:0]               r_cmd;
  logic                     r_sat;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_go;

  assign w_err[0] = err_if.err_1;
  assign w_err[1] = err_if.err_2;
  assign w_err[2] = err_if.err_3;
  assign w_err[3] = err_if.err_4;
  assign w_err[4] = err_if.err_5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    err_if.err_ready = 1'b0;
    busy             = 1'b0;
    w_accept         = 1'b0;
    w_go             = 1'b0;
    w_last           = (r_count + 8'd1) == 8'(BATCH);
    case (r_state)
      ACCUM: begin
        err_if.err_ready = 1'b1;
        w_accept         = err_if.err_valid;
        // A flush only counts if something is (or is being) accumulated.
        w_go             = (w_accept && w_last) ||
                           (flush && (w_accept || r_count != 8'd0));
        if (w_go) w_next = SCALE;
      end
      SCALE: begin
        busy   = 1'b1;
        w_next = COMMIT;
      end
      COMMIT: begin
        busy   = 1'b1;
        w_next = ACCUM;
      end
      default: w_next = ACCUM;
    endcase
  end

  generate
    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
      bias2_scale_sat #(.ACC_W(ACC_W)) u_scale (
        .acc   (r_acc[g]),
        .shift (lr_shift),
        .delta (w_delta[g]),
        .sat   (w_sat[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
      r_cmd   <= 4'b0000;
      r_sat   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        r_acc[i]   <= '0;
        r_delta[i] <= '0;
      end
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_count <= r_count + 8'd1;
            for (int i = 0; i < N_OUT; i++)
              r_acc[i] <= r_acc[i] + ACC_W'(w_err[i]);
          end
        end
        SCALE: begin
          r_count <= 8'd0;
          r_cmd   <= CMD_COMMIT;
          r_sat   <= r_sat | (|w_sat);
          for (int i = 0; i < N_OUT; i++) begin
            r_acc[i]   <= '0;
            r_delta[i] <= w_delta[i];
          end
        end
        COMMIT:  r_cmd <= 4'b0000;
        default: r_cmd <= 4'b0000;
      endcase
    end
  end

  assign ctrl      = r_cmd;
  assign sel       = r_cmd;
  assign sat_flag  = r_sat;
  assign deltab2_1 = r_delta[0];
  assign deltab2_2 = r_delta[1];
  assign deltab2_3 = r_delta[2];
  assign deltab2_4 = r_delta[3];
  assign deltab2_5 = r_delta[4];

endmodule

`default_nettype wire

// File: tb/tb_bias2_delta_gen.sv
// ============================================================================
// Module      : tb_bias2_delta_gen
// Description : Directed and random self-checking bench for bias2_delta_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bias2_delta_gen;
  import bias2_pkg::*;

  localparam int BATCH = 4;
  localparam int ACC_W = 24;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         lr_shift;
  logic               flush;
  logic [3:0]         ctrl;
  logic [3:0]         sel;
  logic signed [15:0] d1, d2, d3, d4, d5;
  logic               busy;
  logic               sat_flag;

  bias2_delta_gen_if ifc ();

  bias2_delta_gen #(.BATCH(BATCH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_if    (ifc),
    .lr_shift  (lr_shift),
    .flush     (flush),
    .ctrl      (ctrl),
    .sel       (sel),
    .deltab2_1 (d1),
    .deltab2_2 (d2),
    .deltab2_3 (d3),
    .deltab2_4 (d4),
    .deltab2_5 (d5),
    .busy      (busy),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int                 checks = 0;
  int                 fails = 0;
  int                 strobes = 0;
  int                 exp_strobes = 0;
  int                 low_cnt = 0;
  bit                 mon_low = 1'b0;
  longint             bank_dut [5] = '{default: 0};
  longint             bank_ref [5] = '{default: 0};
  longint             macc [5] = '{default: 0};
  int                 mcnt = 0;
  logic signed [15:0] e [5];

  // Downstream bias2 bank: adds the deltas whenever it sees the strobe.
  always @(negedge clk) begin
    if (ctrl == CMD_COMMIT) begin
      strobes     <= strobes + 1;
      bank_dut[0] <= bank_dut[0] + longint'(d1);
      bank_dut[1] <= bank_dut[1] + longint'(d2);
      bank_dut[2] <= bank_dut[2] + longint'(d3);
      bank_dut[3] <= bank_dut[3] + longint'(d4);
      bank_dut[4] <= bank_dut[4] + longint'(d5);
    end
    if (mon_low && !ifc.err_ready) low_cnt <= low_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] dval(input int i);
    case (i)
      1:       return d1;
      2:       return d2;
      3:       return d3;
      4:       return d4;
      default: return d5;
    endcase
  endfunction

  function automatic logic signed [15:0] mdelta(input longint acc, input int sh);
    longint n;
    n = -(acc >>> sh);
`ifdef BIAS2_DELTA_SAT_EN
    if (n > 32767)       n = 32767;
    else if (n < -32768) n = -32768;
`endif
    return n[15:0];
  endfunction

  task automatic set_err(input int a, input int b, input int c, input int d, input int f);
    e[0] = 16'(a); e[1] = 16'(b); e[2] = 16'(c); e[3] = 16'(d); e[4] = 16'(f);
    ifc.err_1 = e[0]; ifc.err_2 = e[1]; ifc.err_3 = e[2];
    ifc.err_4 = e[3]; ifc.err_5 = e[4];
  endtask

  // Present the current sample until accepted; returns 1 ns after the accept edge.
  task automatic accept_one(input bit fl, output bit com);
    bit r;
    int n;
    n = 0;
    ifc.err_valid = 1'b1;
    flush = fl;
    do begin
      r = ifc.err_ready;
      @(posedge clk); #1;
      flush = 1'b0;
      n++;
    end while (!r && n < 16);
    chk("accept_wait", r, 1);
    for (int i = 0; i < 5; i++) macc[i] += longint'(e[i]);
    mcnt++;
    com = (mcnt == BATCH) || fl;
  endtask

  // Called 1 ns after the edge that starts SCALE.
  task automatic expect_commit(input string tag);
    logic signed [15:0] ex [5];
    for (int i = 0; i < 5; i++) ex[i] = mdelta(macc[i], int'(lr_shift));
    chk({tag, "_busy_s"}, busy, 1);
    chk({tag, "_rdy_s"}, ifc.err_ready, 0);
    chk({tag, "_ctrl_s"}, ctrl, 0);
    @(posedge clk); #1;
    chk({tag, "_ctrl_c"}, ctrl, 4'hF);
    chk({tag, "_sel_c"}, sel, 4'hF);
    for (int i = 0; i < 5; i++) chk($sformatf("%s_d%0d", tag, i + 1), dval(i + 1), ex[i]);
    @(posedge clk); #1;
    chk({tag, "_ctrl_a"}, ctrl, 0);
    chk({tag, "_rdy_a"}, ifc.err_ready, 1);
    chk({tag, "_busy_a"}, busy, 0);
    for (int i = 0; i < 5; i++) begin
      bank_ref[i] += longint'(ex[i]);
      macc[i] = 0;
    end
    mcnt = 0;
    exp_strobes++;
  endtask

  task automatic flush_pulse();
    ifc.err_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    bit com;
    int s0;
    rst_n = 1'b0; flush = 1'b0; lr_shift = 4'd0; ifc.err_valid = 1'b0;
    set_err(0, 0, 0, 0, 0);
    #12;
    chk("rst_ctrl_in", ctrl, 0);
    chk("rst_rdy_in", ifc.err_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_sel", sel, 0);
    for (int i = 1; i <= 5; i++) chk($sformatf("rst_d%0d", i), dval(i), 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", ifc.err_ready, 1);
    chk("rst_sat", sat_flag, 0);

    // 4 x 100 on lane 1, shift 2 -> -100
    lr_shift = 4'd2;
    set_err(100, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) accept_one(1'b0, com);
    chk("t1_com", com, 1);
    expect_commit("t1");
    ifc.err_valid = 1'b0;
    chk("t1_hand_d1", d1, -100);

    // -3 then flush, shift 1 -> +2; empty flush ignored
    lr_shift = 4'd1;
    set_err(0, -3, 0, 0, 0);
    accept_one(1'b0, com);
    ifc.err_valid = 1'b0;
    @(posedge clk); #1;
    flush_pulse();
    expect_commit("t2");
    chk("t2_hand_d2", d2, 2);
    chk("t2_hand_d1", d1, 0);
    s0 = strobes;
    flush_pulse();
    chk("t2_empty_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_empty_nostrobe", strobes, s0);
    chk("t2_empty_ctrl", ctrl, 0);

    // sample accepted together with flush is included: 8 >>> 3 -> -1
    lr_shift = 4'd3;
    set_err(0, 0, 8, 0, 0);
    accept_one(1'b1, com);
    ifc.err_valid = 1'b0;
    expect_commit("t2b");
    chk("t2b_hand_d3", d3, -1);

    // overflow lane 1: 4 x 32767, shift 0
    lr_shift = 4'd0;
    set_err(32767, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) accept_one(1'b0, com);
    ifc.err_valid = 1'b0;
    expect_commit("t3");
`ifdef BIAS2_DELTA_SAT_EN
    chk("t3_hand_d1", d1, -32768);
    chk("t3_sat", sat_flag, 1);
`else
    chk("t3_hand_d1", d1, 4);
    chk("t3_sat", sat_flag, 0);
`endif

    // valid held high across 3 batches
    lr_shift = 4'd1;
    low_cnt = 0;
    mon_low = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_err(k * 37 - 200, 500 - k * 11, -k, k * 1000, -(k * 2000));
      accept_one(1'b0, com);
      if (com) expect_commit($sformatf("t4_b%0d", k / 4));
    end
    ifc.err_valid = 1'b0;
    mon_low = 1'b0;
    chk("t4_ready_low", low_cnt, 6);

    // reset during COMMIT kills the strobe and the deltas
    lr_shift = 4'd0;
    set_err(5, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) accept_one(1'b0, com);
    ifc.err_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_ctrl_pre", ctrl, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("t5_ctrl", ctrl, 0);
    chk("t5_sel", sel, 0);
    chk("t5_d1", d1, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdy", ifc.err_ready, 1);
    chk("t5_sat", sat_flag, 0);
    for (int i = 0; i < 5; i++) macc[i] = 0;
    mcnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // partial batch lost to a reset, then a fresh batch must need 4 samples
    set_err(7, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) accept_one(1'b0, com);
    ifc.err_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) macc[i] = 0;
    mcnt = 0;
    @(posedge clk); #1;
    set_err(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      accept_one(1'b0, com);
      if (k < 3) chk($sformatf("t5_nobusy%0d", k), busy, 0);
    end
    ifc.err_valid = 1'b0;
    expect_commit("t5b");
    chk("t5b_hand_d1", d1, -4);

    // random traffic, 100 updates
    s0 = exp_strobes;
    while (exp_strobes < s0 + 100) begin
      int r;
      lr_shift = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        flush_pulse();
        if (mcnt > 0) expect_commit("rnd_f");
        else chk("rnd_empty_busy", busy, 0);
      end else if (r == 1) begin
        ifc.err_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        set_err(int'(16'($urandom)), int'(16'($urandom)), int'(16'($urandom)),
                int'(16'($urandom)), int'(16'($urandom)));
        accept_one($urandom_range(0, 7) == 0, com);
        if (com) expect_commit("rnd");
      end
    end
    ifc.err_valid = 1'b0;
    @(posedge clk); #1;

    chk("final_strobes", strobes, exp_strobes);
    for (int i = 0; i < 5; i++) chk($sformatf("final_bank%0d", i + 1), bank_dut[i], bank_ref[i]);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
